// File: rtl/fiber_mem_arbiter_if.sv
// fiber_mem_arbiter_if: write/read requester, read-response and SRAM-pin bundle.
// The arbiter connects via the slave modport; the requesters and SRAM side use master.
interface fiber_mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_data_ready;
    logic [ADDR_W-1:0] addr_to_mem;
    logic [DATA_W-1:0] data_to_mem;
    logic              wen_to_mem;
    logic              ren_to_mem;
    logic [DATA_W-1:0] data_from_mem;

    modport slave (
        input  wr_addr, wr_data, wr_valid, rd_addr, rd_valid, rd_data_ready, data_from_mem,
        output wr_ready, rd_ready, rd_data, rd_data_valid, addr_to_mem, data_to_mem,
               wen_to_mem, ren_to_mem
    );

    modport master (
        output wr_addr, wr_data, wr_valid, rd_addr, rd_valid, rd_data_ready, data_from_mem,
        input  wr_ready, rd_ready, rd_data, rd_data_valid, addr_to_mem, data_to_mem,
               wen_to_mem, ren_to_mem
    );
endinterface

// File: rtl/fiber_mem_arbiter.sv
// fiber_mem_arbiter: single-port SRAM arbiter (write vs read) with a 2-entry credited read-response FIFO.
// Define FIBER_MEM_ARB_WR_PRIO_EN to make writes win every conflict instead of round-robin.
module fiber_mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               flush,
    fiber_mem_arbiter_if.slave bus
);
    typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;

    grant_e            last_grant_q, last_grant_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
    logic              active, rd_req, wr_req, wr_wins, gnt_wr, gnt_rd, push, pop;

    always_comb begin
        active  = rst_n & clk_en & ~flush;
        // a read is only issued when a FIFO slot is guaranteed for its data
        rd_req  = active & bus.rd_valid & (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd2);
        wr_req  = active & bus.wr_valid;
`ifdef FIBER_MEM_ARB_WR_PRIO_EN
        wr_wins = 1'b1;
`else
        wr_wins = (last_grant_q == GNT_RD);
`endif
        gnt_wr  = wr_req & (~rd_req | wr_wins);
        gnt_rd  = rd_req & ~gnt_wr;
        push    = active & inflight_q;
        pop     = active & bus.rd_data_ready & (count_q != 2'd0);
    end

    assign bus.wr_ready      = gnt_wr;
    assign bus.rd_ready      = gnt_rd;
    assign bus.wen_to_mem    = gnt_wr;
    assign bus.ren_to_mem    = gnt_rd;
    assign bus.addr_to_mem   = gnt_wr ? bus.wr_addr : gnt_rd ? bus.rd_addr : {ADDR_W{1'b0}};
    assign bus.data_to_mem   = gnt_wr ? bus.wr_data : {DATA_W{1'b0}};
    assign bus.rd_data       = head_q;
    assign bus.rd_data_valid = (count_q != 2'd0);

    always_comb begin
        last_grant_d = last_grant_q;
        inflight_d   = inflight_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        if (clk_en && flush) begin
            last_grant_d = GNT_RD;
            inflight_d   = 1'b0;
            count_d      = 2'd0;
        end else if (clk_en) begin
            last_grant_d = gnt_wr ? GNT_WR : gnt_rd ? GNT_RD : last_grant_q;
            inflight_d   = gnt_rd;
            count_d      = count_q + {1'b0, push} - {1'b0, pop};
            // head shifts from tail on pop, or takes the returning word when it lands at the front
            head_d       = pop ? ((count_q == 2'd2) ? tail_q : bus.data_from_mem)
                               : ((count_q == 2'd0) && push) ? bus.data_from_mem : head_q;
            tail_d       = (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop)))
                           ? bus.data_from_mem : tail_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_RD;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            head_q       <= {DATA_W{1'b0}};
            tail_q       <= {DATA_W{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end
endmodule

// File: tb/tb_fiber_mem_arbiter.sv
// tb_fiber_mem_arbiter: scoreboard bench; a predictor derives grants and expected read words
// from the arbitration rules, and a monitor checks the response stream against the queue.
module tb_fiber_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 64;
`ifdef FIBER_MEM_ARB_WR_PRIO_EN
    localparam bit WR_PRIO = 1'b1;
`else
    localparam bit WR_PRIO = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } item_t;

    logic clk = 1'b0;
    logic rst_n, clk_en, flush;
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] mm [int];
    item_t exp_q[$];
    int ecyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit last_rd = 1'b1;

    fiber_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fiber_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .flush(flush),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        return {32'(a) * 32'h9E3779B1, ~32'(a)};
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int a);
        return mm.exists(a) ? mm[a] : pat(a);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    // SRAM with a one-cycle read, clocked only on enabled cycles; contents re-pattern during reset
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= pat(i);
        end else if (clk_en) begin
            if (bus.wen_to_mem) sram[bus.addr_to_mem] <= bus.data_to_mem;
            if (bus.ren_to_mem) bus.data_from_mem <= sram[bus.addr_to_mem];
        end
    end

    logic rq, gw, gr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    // predictor: outstanding reads = exp_q entries, credit limit 2
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_grant", {bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem,
                                bus.addr_to_mem, bus.data_to_mem}, '0);
            chk("reset_resp", {bus.rd_data_valid, bus.rd_data}, '0);
            exp_q.delete();
            mm.delete();
            last_rd = 1'b1;
        end else if (!clk_en || flush) begin
            chk("gated_idle", {bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem,
                               bus.addr_to_mem, bus.data_to_mem}, '0);
            if (clk_en) begin
                exp_q.delete();
                last_rd = 1'b1;
            end
        end else begin
            rq = bus.rd_valid && (exp_q.size() < 2);
            gw = bus.wr_valid && (!rq || WR_PRIO || last_rd);
            gr = rq && !gw;
            ea = gw ? bus.wr_addr : gr ? bus.rd_addr : '0;
            ed = gw ? bus.wr_data : '0;
            chk("grant", {bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem,
                          bus.addr_to_mem, bus.data_to_mem}, {gw, gr, gw, gr, ea, ed});
            if (gr) exp_q.push_back('{mem_rd(int'(bus.rd_addr)), ecyc + 2});
            if (gw) mm[int'(bus.wr_addr)] = bus.wr_data;
            if (gw || gr) last_rd = gr;
            ecyc++;
        end
    end

    logic ev;

    // monitor: response visible two enabled cycles after its grant, popped in order
    always @(negedge clk) begin
        #1;
        if (rst_n && clk_en && !flush) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due < ecyc);
            chk("rd_data_valid", 128'(bus.rd_data_valid), 128'(ev));
            if (ev && bus.rd_data_ready) begin
                chk("rd_data", 128'(bus.rd_data), 128'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rv, input logic [AW-1:0] ra, input logic dr,
                        input logic ce, input logic fl);
        bus.wr_valid      = wv;
        bus.wr_addr       = wa;
        bus.wr_data       = wd;
        bus.rd_valid      = rv;
        bus.rd_addr       = ra;
        bus.rd_data_ready = dr;
        clk_en            = ce;
        flush             = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clk_en = 1'b1;
        flush = 1'b0;
        bus.wr_valid = 1'b1;
        bus.rd_valid = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        bus.rd_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 9'h05, 64'hDEAD_BEEF, 0, 0, 1, 1, 0);
        step(1, 9'h03, 64'h11, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 9'h03, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 9'(i), 64'(i + 100), 1, 9'(i + 8), 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1, 1, 0);
        repeat (6) step(0, 0, 0, 1, 9'h05, 0, 1, 0);
        step(0, 0, 0, 1, 9'h03, 1, 1, 0);
        repeat (4) step(0, 0, 0, 1, 9'h06, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 9'h07, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) step(1, 9'h0A, 64'hA5, 1, 9'h0B, 1, 1, 0);
        repeat (3) step(1, 9'h0A, 64'hA6, 1, 9'h0B, 1, 0, 0);
        repeat (4) step(1, 9'h0C, 64'hA7, 1, 9'h0A, 1, 1, 0);
        step(1, 9'h02, 64'h77, 1, 9'h04, 0, 1, 0);
        rst_n = 1'b0;
        repeat (2) step(1, 9'h02, 64'h78, 1, 9'h02, 1, 1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 50, 9'($urandom_range(0, 15)), {$urandom, $urandom},
                 $urandom_range(0, 99) < 60, 9'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) >= 8,
                 $urandom_range(0, 99) < 2);
        repeat (6) step(0, 0, 0, 0, 0, 1, 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
